lookahead_output_allocator: RTL and testbench

//  Per-output-port switch allocator and credit tracker for the lookahead router

---
 rtl/lookahead_output_allocator_if.sv | 25 ++
 rtl/lookahead_output_allocator.sv | 150 +++++++++++++++
 tb/tb_lookahead_output_allocator.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/lookahead_output_allocator_if.sv
// lookahead_output_allocator_if - input-port request/grant bundle for one router output
//   req_in    : input i has a flit routed to this output at its buffer head
//   head_in   : flit at input i is a head flit
//   tail_in   : flit at input i is a tail flit (head&tail = single-flit packet)
//   grant_out : one-hot dequeue strobe back to input i
interface lookahead_output_allocator_if;
    logic [4:0] req_in;
    logic [4:0] head_in;
    logic [4:0] tail_in;
    logic [4:0] grant_out;

    modport master (
        output req_in,
        output head_in,
        output tail_in,
        input  grant_out
    );

    modport slave (
        input  req_in,
        input  head_in,
        input  tail_in,
        output grant_out
    );
endinterface

// File: rtl/lookahead_output_allocator.sv
// lookahead_output_allocator - wormhole switch allocator and credit tracker for one output
//   clk           : router clock
//   rst           : asynchronous active-low reset
//   port_if       : req/head/tail in, one-hot combinational grant out (5 inputs N,S,W,E,P)
//   credit_in     : one-cycle pulse, downstream freed a buffer slot
//   xbar_sel_out  : registered index of the input whose flit was sent last cycle
//   valid_out     : registered, output flit valid this cycle
//   credits_out   : current credit count
//   locked_out    : a packet currently owns the output
//   err_out       : sticky credit overflow / protocol violation flag
module lookahead_output_allocator #(
    parameter int          Credits   = 4,
    parameter logic [4:0]  InputMask = 5'b11111,
    localparam int         CntW      = $clog2(Credits + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    lookahead_output_allocator_if.slave port_if,
    input  logic                     credit_in,
    output logic [2:0]               xbar_sel_out,
    output logic                     valid_out,
    output logic [CntW-1:0]          credits_out,
    output logic                     locked_out,
    output logic                     err_out
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state, next_state;
    logic [2:0]      rr_ptr;
    logic [2:0]      owner;
    logic [CntW-1:0] credits;

    logic [4:0]      eligible;
    logic [4:0]      cand;
    logic [4:0]      grant;
    logic [2:0]      grant_idx;
    logic [2:0]      win_idx;
    logic            win_found;
    logic [3:0]      scan_idx;
    logic            has_credit;
    logic            fire;
    logic            err_set;

    assign eligible   = port_if.req_in & InputMask;
    assign cand       = eligible & port_if.head_in;
    assign has_credit = (credits != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        grant      = '0;
        grant_idx  = 3'd0;
        win_found  = 1'b0;
        win_idx    = 3'd0;
        scan_idx   = 4'd0;
        // Round-robin scan starting just after the last winner.
        for (int k = 1; k <= 5; k++) begin
            scan_idx = {1'b0, rr_ptr} + 4'(k);
            if (scan_idx >= 4'd5) begin
                scan_idx = scan_idx - 4'd5;
            end
            if (!win_found && cand[scan_idx[2:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[2:0];
            end
        end
        case (state)
            IDLE: begin
                if (win_found && has_credit) begin
                    grant[win_idx] = 1'b1;
                    grant_idx      = win_idx;
                    if (!port_if.tail_in[win_idx]) begin
                        next_state = LOCKED;
                    end
                end
            end
            LOCKED: begin
                // Only the owning packet may advance; gaps simply hold the lock.
                if (eligible[owner] && has_credit) begin
                    grant[owner] = 1'b1;
                    grant_idx    = owner;
                    if (port_if.tail_in[owner]) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (!rst) begin
            grant      = '0;
            next_state = IDLE;
        end
    end

    assign fire              = |grant;
    assign port_if.grant_out = grant;

    // Head arriving on the owner mid-packet, or any request on a masked input.
    assign err_set = ((state == LOCKED) && port_if.req_in[owner] && port_if.head_in[owner])
                   || (|(port_if.req_in & ~InputMask));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= 3'd4;
            owner        <= 3'd0;
            credits      <= CntW'(Credits);
            xbar_sel_out <= 3'd0;
            valid_out    <= 1'b0;
            err_out      <= 1'b0;
        end else begin
            valid_out <= fire;
            if (fire) begin
                xbar_sel_out <= grant_idx;
            end
            if ((state == IDLE) && fire) begin
                rr_ptr <= grant_idx;
                owner  <= grant_idx;
            end
            case ({fire, credit_in})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits == CntW'(Credits)) begin
                        err_out <= 1'b1;
                    end else begin
                        credits <= credits + 1'b1;
                    end
                end
                default: credits <= credits;
            endcase
            if (err_set) begin
                err_out <= 1'b1;
            end
        end
    end

    assign credits_out = credits;
    assign locked_out  = (state == LOCKED);

endmodule

// File: tb/tb_lookahead_output_allocator.sv
// tb/tb_lookahead_output_allocator.sv - directed vector bench for lookahead_output_allocator
module tb_lookahead_output_allocator;

    logic       clk;
    logic       rst;
    logic       credit_a;
    logic       credit_b;
    logic [2:0] sel_a, sel_b;
    logic       valid_a, valid_b;
    logic [2:0] cred_a, cred_b;
    logic       locked_a, locked_b;
    logic       err_a, err_b;

    int checks;
    int errors;

    lookahead_output_allocator_if if_a ();
    lookahead_output_allocator_if if_b ();

    lookahead_output_allocator #(.Credits(4), .InputMask(5'b11111)) dut_a (
        .clk          (clk),
        .rst          (rst),
        .port_if      (if_a.slave),
        .credit_in    (credit_a),
        .xbar_sel_out (sel_a),
        .valid_out    (valid_a),
        .credits_out  (cred_a),
        .locked_out   (locked_a),
        .err_out      (err_a)
    );

    lookahead_output_allocator #(.Credits(4), .InputMask(5'b01111)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .port_if      (if_b.slave),
        .credit_in    (credit_b),
        .xbar_sel_out (sel_b),
        .valid_out    (valid_b),
        .credits_out  (cred_b),
        .locked_out   (locked_b),
        .err_out      (err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] req;
        logic [4:0] head;
        logic [4:0] tail;
        logic       credit;
        logic [4:0] grant;
        logic       valid;
        logic [2:0] sel;
        logic [2:0] cred;
        logic       locked;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [4:0] req, input logic [4:0] head,
                                input logic [4:0] tail, input logic credit,
                                input logic [4:0] grant, input logic valid,
                                input logic [2:0] sel, input logic [2:0] cred,
                                input logic locked, input logic err);
        vec_t v;
        v.req = req; v.head = head; v.tail = tail; v.credit = credit;
        v.grant = grant; v.valid = valid; v.sel = sel; v.cred = cred;
        v.locked = locked; v.err = err;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_a(input logic [4:0] req, input logic [4:0] head,
                           input logic [4:0] tail, input logic credit);
        if_a.req_in  = req;
        if_a.head_in = head;
        if_a.tail_in = tail;
        credit_a     = credit;
    endtask

    task automatic drive_b(input logic [4:0] req, input logic [4:0] head,
                           input logic [4:0] tail);
        if_b.req_in  = req;
        if_b.head_in = head;
        if_b.tail_in = tail;
        credit_b     = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // RR: single-flit packets on all inputs, credit returned every cycle
        add(5'h1F, 5'h1F, 5'h1F, 1, 5'b00001, 0, 3'd0, 3'd4, 0, 0);
        add(5'h1F, 5'h1F, 5'h1F, 1, 5'b00010, 1, 3'd0, 3'd4, 0, 0);
        add(5'h1F, 5'h1F, 5'h1F, 1, 5'b00100, 1, 3'd1, 3'd4, 0, 0);
        add(5'h1F, 5'h1F, 5'h1F, 1, 5'b01000, 1, 3'd2, 3'd4, 0, 0);
        add(5'h1F, 5'h1F, 5'h1F, 1, 5'b10000, 1, 3'd3, 3'd4, 0, 0);
        add(5'h1F, 5'h1F, 5'h1F, 1, 5'b00001, 1, 3'd4, 3'd4, 0, 0);
        add(5'h00, 5'h00, 5'h00, 0, 5'b00000, 1, 3'd0, 3'd4, 0, 0);
        add(5'h00, 5'h00, 5'h00, 0, 5'b00000, 0, 3'd0, 3'd4, 0, 0);
        // Wormhole: input 2 three-flit packet while input 0 waits
        add(5'b00101, 5'b00101, 5'b00001, 0, 5'b00100, 0, 3'd0, 3'd4, 0, 0);
        add(5'b00101, 5'b00001, 5'b00001, 0, 5'b00100, 1, 3'd2, 3'd3, 1, 0);
        add(5'b00101, 5'b00001, 5'b00101, 0, 5'b00100, 1, 3'd2, 3'd2, 1, 0);
        add(5'b00001, 5'b00001, 5'b00001, 0, 5'b00001, 1, 3'd2, 3'd1, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 1, 3'd0, 3'd0, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd0, 3'd0, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd0, 3'd1, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd0, 3'd2, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd0, 3'd3, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd0, 3'd4, 0, 0);
        // Credit stall: input 1 long packet with no returning credit
        add(5'b00010, 5'b00010, 5'b00000, 0, 5'b00010, 0, 3'd0, 3'd4, 0, 0);
        add(5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 1, 3'd1, 3'd3, 1, 0);
        add(5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 1, 3'd1, 3'd2, 1, 0);
        add(5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 1, 3'd1, 3'd1, 1, 0);
        add(5'b00010, 5'b00000, 5'b00000, 0, 5'b00000, 1, 3'd1, 3'd0, 1, 0);
        add(5'b00010, 5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd1, 3'd0, 1, 0);
        add(5'b00010, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd1, 3'd0, 1, 0);
        add(5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 0, 3'd1, 3'd1, 1, 0);
        add(5'b00010, 5'b00000, 5'b00000, 0, 5'b00000, 1, 3'd1, 3'd0, 1, 0);
        add(5'b00010, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd1, 3'd0, 1, 0);
        add(5'b00010, 5'b00000, 5'b00010, 0, 5'b00010, 0, 3'd1, 3'd1, 1, 0);
        add(5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 1, 3'd1, 3'd0, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd1, 3'd0, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd1, 3'd1, 0, 0);
        // Fire together with credit return at credits=2, then overflow at 4
        add(5'b01000, 5'b01000, 5'b01000, 1, 5'b01000, 0, 3'd1, 3'd2, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 1, 3'd3, 3'd2, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd3, 3'd2, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd3, 3'd3, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd3, 3'd4, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 3'd3, 3'd4, 0, 0);
        add(5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 3'd3, 3'd4, 0, 1);

        // Reset with every input requesting
        rst = 1'b0;
        drive_a(5'h1F, 5'h1F, 5'h1F, 1'b0);
        drive_b(5'h00, 5'h00, 5'h00);
        #1;
        chk("rst_grant", 0, {3'b0, if_a.grant_out}, 8'h00);
        @(negedge clk);
        chk("rst_credits", 0, {5'b0, cred_a}, 8'd4);
        chk("rst_valid", 0, {7'b0, valid_a}, 8'd0);
        chk("rst_err", 0, {7'b0, err_a}, 8'd0);
        chk("rst_locked", 0, {7'b0, locked_a}, 8'd0);
        chk("rst_sel", 0, {5'b0, sel_a}, 8'd0);
        drive_a(5'h00, 5'h00, 5'h00, 1'b0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive_a(vecs[i].req, vecs[i].head, vecs[i].tail, vecs[i].credit);
            #1;
            chk("grant", i, {3'b0, if_a.grant_out}, {3'b0, vecs[i].grant});
            chk("valid", i, {7'b0, valid_a}, {7'b0, vecs[i].valid});
            chk("xbar_sel", i, {5'b0, sel_a}, {5'b0, vecs[i].sel});
            chk("credits", i, {5'b0, cred_a}, {5'b0, vecs[i].cred});
            chk("locked", i, {7'b0, locked_a}, {7'b0, vecs[i].locked});
            chk("err", i, {7'b0, err_a}, {7'b0, vecs[i].err});
        end

        // Reset in the middle of a packet: rr_ptr=3 so input 0 wins
        @(negedge clk);
        drive_a(5'b00001, 5'b00001, 5'b00000, 1'b0);
        #1;
        chk("mid_head_grant", 0, {3'b0, if_a.grant_out}, 8'b00001);
        @(negedge clk);
        drive_a(5'b00001, 5'b00000, 5'b00000, 1'b0);
        #1;
        chk("mid_locked", 0, {7'b0, locked_a}, 8'd1);
        chk("mid_credits", 0, {5'b0, cred_a}, 8'd3);
        rst = 1'b0;
        #1;
        chk("mid_rst_grant", 0, {3'b0, if_a.grant_out}, 8'd0);
        chk("mid_rst_locked", 0, {7'b0, locked_a}, 8'd0);
        chk("mid_rst_credits", 0, {5'b0, cred_a}, 8'd4);
        chk("mid_rst_err", 0, {7'b0, err_a}, 8'd0);
        chk("mid_rst_valid", 0, {7'b0, valid_a}, 8'd0);
        @(negedge clk);
        drive_a(5'b00000, 5'b00000, 5'b00000, 1'b0);
        rst = 1'b1;

        // Masked input 4 on the second instance
        @(negedge clk);
        drive_b(5'b10000, 5'b10000, 5'b10000);
        #1;
        chk("mask_grant", 0, {3'b0, if_b.grant_out}, 8'd0);
        chk("mask_err_pre", 0, {7'b0, err_b}, 8'd0);
        @(negedge clk);
        drive_b(5'b11000, 5'b11000, 5'b11000);
        #1;
        chk("mask_grant_mixed", 0, {3'b0, if_b.grant_out}, 8'b01000);
        chk("mask_err", 0, {7'b0, err_b}, 8'd1);
        @(negedge clk);
        drive_b(5'b10000, 5'b10000, 5'b10000);
        #1;
        chk("mask_grant_again", 0, {3'b0, if_b.grant_out}, 8'd0);
        chk("mask_valid", 0, {7'b0, valid_b}, 8'd1);
        chk("mask_sel", 0, {5'b0, sel_b}, 8'd3);
        chk("mask_credits", 0, {5'b0, cred_b}, 8'd3);
        @(negedge clk);
        drive_b(5'b00000, 5'b00000, 5'b00000);
        #1;
        chk("mask_err_sticky", 0, {7'b0, err_b}, 8'd1);
        chk("mask_locked", 0, {7'b0, locked_b}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
